svnet_accum_ram: RTL and testbench
==================================

# svnet_accum_ram

Single-port-write, single-port-read on-chip RAM with a per-write accumulate mode, coherent read-after-write forwarding, and a hardware clear sweep. It is the next-generation storage primitive for partial-sum buffers in convolution layers. Producers either store a word or add a signed value to the stored word, with no external read-modify-write loop. Consumers read with fixed 2-cycle latency.

## Interface
Parameters:
- DEPTH, 16, number of words; minimum 2; need not be a power of two.
- WIDTH, 16, word width in bits; words are signed two's complement.
- SATURATE, 1, 1: accumulate saturates to the WIDTH signed range; 0: accumulate wraps modulo 2^WIDTH.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- ready  out  1  1 when the block accepts write/read/clear; 0 during a clear sweep.
- clear  in  1  request to zero all DEPTH words.
- write  in  1  write request.
- write_mode  in  1  0: store write_data; 1: accumulate, word <= word + write_data.
- write_address  in  $clog2(DEPTH)  target word.
- write_data  in  WIDTH  store value or addend.
- read  in  1  read request.
- read_address  in  $clog2(DEPTH)  word to read.
- read_data_valid  out  1  one-cycle strobe qualifying read_data.
- read_data  out  WIDTH  read result; registered.

## Operation
- Inputs are registered, then processed through three stages:
  - Stage I (input registers).
  - Stage A (operand fetch).
  - Stage B (result register).
- Commit: RAM write happens at the edge leaving stage B.
- Write pipeline:
  - Stage A operand = stage B result if B is valid and has the same address; otherwise the RAM word.
  - Stage B result = write_data (store), or operand + write_data (accumulate).
  - With SATURATE=1: positive overflow -> 2^(WIDTH-1)-1; negative overflow -> -2^(WIDTH-1).
  - Back-to-back accumulates to one address therefore never lose an update.
- Read coherence: a read returns the word including every accepted write issued in earlier cycles. Reads forward from stage B on an address match. A write issued in the same cycle as a read is not visible to that read.
- FSM states:
  - CLEAR: a sweep counter writes 0 to address 0..DEPTH-1, one word per cycle, and ready=0. When the counter reaches DEPTH-1, the FSM moves to RUN.
  - RUN: ready=1. A clear accepted in RUN moves the FSM to CLEAR with the counter at 0.
- Accepting clear squashes stages I/A/B: uncommitted writes are dropped. A read already in stage I completes with pre-clear data.
- Simultaneous clear and write in one cycle: clear wins and the write is dropped. A read presented in the same cycle is still served with pre-clear data.
- write, read, or clear while ready=0 is ignored. An assertion flags it, disabled while rst=1.
- An address >= DEPTH on an accepted request fires an assertion; its RAM effect is undefined.

## Timing
- Reset values (cycle after rst sampled high):
  - read_data_valid=0, read_data=0, ready=0.
  - Pipeline valids 0; FSM in CLEAR with counter 0.
- Reset therefore clears the RAM, and ready rises DEPTH cycles after rst deasserts.
- Reset mid-operation (including mid-sweep) squashes everything and restarts the sweep at 0.
- Read latency: read presented in cycle n -> read_data_valid=1 with data in cycle n+2, for exactly one cycle. Throughput is one read per cycle.
- Write throughput: one write per cycle in either mode. A write presented in cycle n is committed to RAM at the end of cycle n+2. It is visible to reads presented in cycle n+1 onward.
- Clear presented in cycle n -> ready=0 from cycle n+1 through n+DEPTH, and ready=1 in cycle n+DEPTH+1.
- A read presented in cycle n+DEPTH+1 returns 0 for every never-rewritten address.

## Test plan
- Reset with DEPTH=8, WIDTH=8 -> ready low 8 cycles then high; reads of addresses 0-7 each return 0 with 2-cycle latency.
- Store 0x10 to addr 3, then accumulate +5 in three consecutive cycles to addr 3 -> read in the next cycle returns 0x1F; no update is lost.
- SATURATE=1: store 120 to addr 1, accumulate +20 -> read returns 127. Store -120, accumulate -20 -> -128. SATURATE=0: 120+20 -> -116.
- Write addr 2=0x33 in cycle n with a read of addr 2 in cycle n (returns old 0) and in cycle n+1 (returns 0x33).
- Clear presented together with a write of 0x44 to addr 5 -> after the sweep, addr 5 reads 0; writes and reads during ready=0 are ignored and flagged.
- Assert rst mid-sweep at counter 4, after addresses 6-7 hold nonzero data -> sweep restarts at 0; after ready, all 8 words read 0.

Source files
------------

// File: rtl/svnet_accum_ram.sv
// svnet_accum_ram
// On-chip word store for partial-sum buffers. Each write either stores a
// value or adds a signed addend to the stored word; the read-modify-write
// happens internally and back-to-back updates to one word are forwarded so
// none is lost. Reads return data two cycles after the request. A clear
// request (and reset) runs a hardware sweep that zeroes every word.
//
// Ports
//   clk             : sole clock, rising edge
//   rst             : synchronous active-high reset
//   ready           : 1 when write/read/clear are accepted, 0 during a sweep
//   clear           : request to zero all DEPTH words
//   write           : write request
//   write_mode      : 0 store write_data, 1 accumulate word + write_data
//   write_address   : target word of the write
//   write_data      : store value or signed addend
//   read            : read request
//   read_address    : word to read
//   read_data_valid : one-cycle strobe qualifying read_data
//   read_data       : registered read result
module svnet_accum_ram #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 16,
  parameter int SATURATE = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             clear,
  input  logic             write,
  input  logic             write_mode,
  input  logic [AW-1:0]    write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read,
  input  logic [AW-1:0]    read_address,
  output logic             read_data_valid,
  output logic [WIDTH-1:0] read_data
);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  // Clamp a WIDTH+1 bit signed sum to the WIDTH range, or wrap it.
  function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH:0] s);
    logic [WIDTH-1:0] res;
    if ((SATURATE != 0) && (s[WIDTH] != s[WIDTH-1])) begin
      if (s[WIDTH]) res = {1'b1, {(WIDTH-1){1'b0}}};
      else          res = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = s[WIDTH-1:0];
    end
    return res;
  endfunction

  logic [WIDTH-1:0] r_mem [DEPTH];

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_ready;

  logic             r_i_wr;
  logic             r_i_mode;
  logic [AW-1:0]    r_i_waddr;
  logic [WIDTH-1:0] r_i_wdata;
  logic             r_i_rd;
  logic [AW-1:0]    r_i_raddr;

  logic             r_b_valid;
  logic [AW-1:0]    r_b_addr;
  logic [WIDTH-1:0] r_b_data;

  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;

  logic             w_clear_acc;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_operand;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_rd_word;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_data;

  // Clear beats a same-cycle write; nothing is accepted while sweeping.
  assign w_clear_acc = clear & r_ready;
  assign w_wr_acc    = write & r_ready & ~clear;
  assign w_rd_acc    = read & r_ready;

  // Stage A: the word still in stage B is newer than the RAM copy.
  assign w_operand = (r_b_valid && (r_b_addr == r_i_waddr)) ? r_b_data : r_mem[r_i_waddr];
  assign w_sum     = {w_operand[WIDTH-1], w_operand} + {r_i_wdata[WIDTH-1], r_i_wdata};
  assign w_result  = r_i_mode ? f_sat(w_sum) : r_i_wdata;

  // Reads see stage B (write issued the cycle before) ahead of the RAM.
  assign w_rd_word = (r_b_valid && (r_b_addr == r_i_raddr)) ? r_b_data : r_mem[r_i_raddr];

  assign ready           = r_ready;
  assign read_data_valid = r_rd_valid;
  assign read_data       = r_rd_data;

  // RAM write port: sweep zeroes during CLEAR, otherwise stage B commits.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_b_addr;
    w_mem_data = r_b_data;
    if (rst) begin
      w_mem_we = 1'b0;
    end else if (r_state == ST_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_cnt;
      w_mem_data = {WIDTH{1'b0}};
    end else begin
      w_mem_we = r_b_valid;
    end
  end

  // Storage array, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Sweep FSM: CLEAR walks the counter over every word, RUN accepts traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= {AW{1'b0}};
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_cnt   <= {AW{1'b0}};
            r_ready <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
            r_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_cnt   <= {AW{1'b0}};
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= {AW{1'b0}};
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline: stage I capture, stage B result, read output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_wr     <= 1'b0;
      r_i_mode   <= 1'b0;
      r_i_waddr  <= {AW{1'b0}};
      r_i_wdata  <= {WIDTH{1'b0}};
      r_i_rd     <= 1'b0;
      r_i_raddr  <= {AW{1'b0}};
      r_b_valid  <= 1'b0;
      r_b_addr   <= {AW{1'b0}};
      r_b_data   <= {WIDTH{1'b0}};
      r_rd_valid <= 1'b0;
      r_rd_data  <= {WIDTH{1'b0}};
    end else begin
      r_i_wr    <= w_wr_acc;
      r_i_mode  <= write_mode;
      r_i_waddr <= write_address;
      r_i_wdata <= write_data;
      r_i_rd    <= w_rd_acc;
      r_i_raddr <= read_address;
      // A clear drops the write sitting in stage I; the one leaving B commits.
      r_b_valid <= r_i_wr & ~w_clear_acc;
      r_b_addr  <= r_i_waddr;
      r_b_data  <= w_result;
      // A read already in stage I always completes, even across a clear.
      r_rd_valid <= r_i_rd;
      if (r_i_rd) r_rd_data <= w_rd_word;
      else        r_rd_data <= r_rd_data;
    end
  end

  // Requests while not ready are dropped; flag them.
  a_req_not_ready: assert property (@(posedge clk) disable iff (rst)
    !ready |-> !(write || read || clear))
    else $warning("svnet_accum_ram: request while not ready ignored");

  // Accepted addresses must be inside the array.
  a_waddr_range: assert property (@(posedge clk) disable iff (rst)
    (ready && write) |-> (int'(write_address) < DEPTH))
    else $error("svnet_accum_ram: write address out of range");

  a_raddr_range: assert property (@(posedge clk) disable iff (rst)
    (ready && read) |-> (int'(read_address) < DEPTH))
    else $error("svnet_accum_ram: read address out of range");

endmodule

// File: tb/tb_svnet_accum_ram.sv
module tb_svnet_accum_ram;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             write = 1'b0;
  logic             write_mode = 1'b0;
  logic [2:0]       write_address = 3'd0;
  logic [WIDTH-1:0] write_data = 8'd0;
  logic             read = 1'b0;
  logic             read_w = 1'b0;
  logic [2:0]       read_address = 3'd0;

  logic             ready_s, rdv_s, ready_w, rdv_w;
  logic [WIDTH-1:0] rd_s, rd_w;

  svnet_accum_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .ready(ready_s), .clear(clear), .write(write),
    .write_mode(write_mode), .write_address(write_address), .write_data(write_data),
    .read(read), .read_address(read_address), .read_data_valid(rdv_s), .read_data(rd_s));

  svnet_accum_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .ready(ready_w), .clear(clear), .write(write),
    .write_mode(write_mode), .write_address(write_address), .write_data(write_data),
    .read(read_w), .read_address(read_address), .read_data_valid(rdv_w), .read_data(rd_w));

  typedef struct {int cyc; logic [7:0] data;} exp_t;
  exp_t q_s[$];
  exp_t q_w[$];

  logic [7:0] mdl_s [DEPTH];
  logic [7:0] mdl_w [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int m_lo = 0;
  int m_hi = 1000000;
  logic exp_rdy;

  // Cycle counter: cycle k is the period after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] acc_f(input logic [7:0] a, input logic [7:0] b, input bit sat);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (sat) begin
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
    end
    return s[7:0];
  endfunction

  // Monitor: ready schedule and read scoreboards, sampled mid-cycle.
  always @(negedge clk) begin
    exp_rdy = !(cyc >= m_lo && cyc <= m_hi);
    n_cmp++;
    if (ready_s !== exp_rdy || ready_w !== exp_rdy) begin
      n_bad++;
      $display("FAIL ready cyc=%0d got s=%b w=%b expected %b", cyc, ready_s, ready_w, exp_rdy);
    end
    while (q_s.size() > 0 && q_s[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL read_missing_s cyc=%0d expected data %h at cyc %0d, no valid", cyc, q_s[0].data, q_s[0].cyc);
      void'(q_s.pop_front());
    end
    if (rdv_s === 1'b1) begin
      n_cmp++;
      if (q_s.size() > 0 && q_s[0].cyc == cyc) begin
        if (rd_s !== q_s[0].data) begin
          n_bad++;
          $display("FAIL read_data_s cyc=%0d got %h expected %h", cyc, rd_s, q_s[0].data);
        end
        void'(q_s.pop_front());
      end else begin
        n_bad++;
        $display("FAIL read_unexpected_s cyc=%0d got valid data %h expected no valid", cyc, rd_s);
      end
    end
    while (q_w.size() > 0 && q_w[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL read_missing_w cyc=%0d expected data %h at cyc %0d, no valid", cyc, q_w[0].data, q_w[0].cyc);
      void'(q_w.pop_front());
    end
    if (rdv_w === 1'b1) begin
      n_cmp++;
      if (q_w.size() > 0 && q_w[0].cyc == cyc) begin
        if (rd_w !== q_w[0].data) begin
          n_bad++;
          $display("FAIL read_data_w cyc=%0d got %h expected %h", cyc, rd_w, q_w[0].data);
        end
        void'(q_w.pop_front());
      end else begin
        n_bad++;
        $display("FAIL read_unexpected_w cyc=%0d got valid data %h expected no valid", cyc, rd_w);
      end
    end
  end

  // Drive one cycle of stimulus and update the model / scoreboards.
  task automatic drive(input bit w, input bit m, input int wa, input logic [7:0] wd,
                       input bit r, input int ra, input bit c, input bit rw);
    bit acc;
    exp_t e;
    acc = !(cyc >= m_lo && cyc <= m_hi);
    write = w; write_mode = m; write_address = 3'(wa); write_data = wd;
    read = r; read_w = rw; read_address = 3'(ra); clear = c;
    if (acc) begin
      if (r) begin e.cyc = cyc + 2; e.data = mdl_s[ra]; q_s.push_back(e); end
      if (rw) begin e.cyc = cyc + 2; e.data = mdl_w[ra]; q_w.push_back(e); end
      if (c) begin
        for (int i = 0; i < DEPTH; i++) begin mdl_s[i] = 8'd0; mdl_w[i] = 8'd0; end
        m_lo = cyc + 1;
        m_hi = cyc + DEPTH;
      end else if (w) begin
        mdl_s[wa] = m ? acc_f(mdl_s[wa], wd, 1'b1) : wd;
        mdl_w[wa] = m ? acc_f(mdl_w[wa], wd, 1'b0) : wd;
      end
    end
    @(posedge clk); #1;
    write = 1'b0; write_mode = 1'b0; read = 1'b0; read_w = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 8'd0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic read_all(input bit rw);
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 1'b0, 0, 8'd0, 1'b1, a, 1'b0, rw);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin mdl_s[i] = 8'd0; mdl_w[i] = 8'd0; end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rdv_s !== 1'b0 || rd_s !== 8'd0 || ready_s !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state_s got valid=%b data=%h ready=%b expected 0/00/0", rdv_s, rd_s, ready_s);
    end
    n_cmp++;
    if (rdv_w !== 1'b0 || rd_w !== 8'd0 || ready_w !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state_w got valid=%b data=%h ready=%b expected 0/00/0", rdv_w, rd_w, ready_w);
    end
    rst = 1'b0;
    m_hi = cyc + DEPTH - 1;
    idle(DEPTH);
    read_all(1'b1);
    idle(3);
  endtask

  task automatic test_accumulate;
    drive(1'b1, 1'b0, 3, 8'h10, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3, 8'h05, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3, 8'h05, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3, 8'h05, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 8'h00, 1'b1, 3, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_saturate;
    drive(1'b1, 1'b0, 1, 8'd120, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1, 8'd20, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 8'd0, 1'b1, 1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1, 8'h88, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1, 8'hEC, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 8'd0, 1'b1, 1, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_raw;
    drive(1'b1, 1'b0, 2, 8'h33, 1'b1, 2, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, 8'h00, 1'b1, 2, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_clear;
    drive(1'b1, 1'b0, 5, 8'h12, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 1'b0, 5, 8'h44, 1'b1, 3, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 5, 8'h55, 1'b1, 5, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 5, 8'h01, 1'b1, 5, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 0, 8'h00, 1'b1, 5, 1'b0, 1'b1);
    while (cyc <= m_hi) idle(1);
    read_all(1'b1);
    idle(3);
  endtask

  task automatic test_reset_mid_sweep;
    drive(1'b1, 1'b0, 6, 8'h66, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 7, 8'h77, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1, 1'b0);
    idle(4);
    rst = 1'b1;
    m_hi = 1000000;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = cyc + DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin mdl_s[i] = 8'd0; mdl_w[i] = 8'd0; end
    idle(DEPTH);
    read_all(1'b1);
    idle(3);
  endtask

  task automatic test_back_to_back;
    bit r;
    for (int i = 0; i < 60; i++) begin
      r = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            8'($urandom), r, int'($urandom_range(0, 7)), 1'b0, r);
    end
    read_all(1'b1);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_saturate();
    test_raw();
    test_clear();
    test_reset_mid_sweep();
    test_back_to_back();
    idle(3);
    n_cmp++;
    if (q_s.size() != 0 || q_w.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d/%0d pending reads expected 0/0", q_s.size(), q_w.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
